// File: rtl/mux32_1_pipe_pkg.sv
// Shared constants for the two-stage 32:1 bit-select pipeline.
// Selection is split into a low field (bit within a group) and a high field (group index).
package mux32_1_pipe_pkg;
  localparam int N_IN     = 32;
  localparam int SEL_W    = 5;
  localparam int GRP_W    = 8;
  localparam int N_GRP    = 4;
  localparam int SEL_LO_W = 3;
  localparam int SEL_HI_W = SEL_W - SEL_LO_W;
endpackage

// File: rtl/mux32_1_pipe_if.sv
// Request/result bundle for mux32_1_pipe.
// The master drives the select request and the slave returns the registered bit.
interface mux32_1_pipe_if;
  import mux32_1_pipe_pkg::*;

  logic             in_valid;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0]  in;
  logic             out;
  logic             out_valid;

  modport master (
    output in_valid, sel, in,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, sel, in,
    output out, out_valid
  );
endinterface

// File: rtl/mux32_1_pipe_mux4_1.sv
// Combinational 4:1 selector that picks one registered group result.
module mux4_1
  import mux32_1_pipe_pkg::*;
(
  input  logic [N_GRP-1:0]    din,
  input  logic [SEL_HI_W-1:0] sel,
  output logic                dout
);
  assign dout = din[sel];
endmodule

// File: rtl/mux32_1_pipe_mux8_1.sv
// Combinational 8:1 bit selector used for each stage-1 group.
module mux8_1
  import mux32_1_pipe_pkg::*;
(
  input  logic [GRP_W-1:0]    din,
  input  logic [SEL_LO_W-1:0] sel,
  output logic                dout
);
  // Plain indexing keeps unselected bits out of the result.
  assign dout = din[sel];
endmodule

// File: rtl/mux32_1_pipe.sv
// Two-stage 32:1 bit selector: four 8:1 groups registered, then a 4:1 pick registered.
// Every register in the design is here; the mux leaves are purely combinational.
module mux32_1_pipe
  import mux32_1_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mux32_1_pipe_if.slave  bus
);

  logic [N_GRP-1:0]    grp_d;
  logic [N_GRP-1:0]    grp_q;
  logic [SEL_HI_W-1:0] sel_hi_q;
  logic                vld_q;
  logic                pick;
  logic                out_q;
  logic                out_vld_q;

  genvar g;
  generate
    for (g = 0; g < N_GRP; g++) begin : g_grp
      mux8_1 u_mux8 (
        .din  (bus.in[g*GRP_W +: GRP_W]),
        .sel  (bus.sel[SEL_LO_W-1:0]),
        .dout (grp_d[g])
      );
    end
  endgenerate

  mux4_1 u_mux4 (
    .din  (grp_q),
    .sel  (sel_hi_q),
    .dout (pick)
  );

  // Stage 1: the valid bit always advances; data loads only with a valid request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q    <= '0;
      sel_hi_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        grp_q    <= grp_d;
        sel_hi_q <= bus.sel[SEL_W-1:SEL_LO_W];
      end
    end
  end

  // Stage 2: out holds its last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= vld_q;
      if (vld_q) out_q <= pick;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_vld_q;

endmodule

// File: tb/tb_mux32_1_pipe.sv
// Self-checking bench for mux32_1_pipe: directed vector table, hand sequences and random streams.
// Expected results come from in[sel] and a two-sample delay line with hold-on-bubble.
module tb_mux32_1_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux32_1_pipe_if bus ();

  mux32_1_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       e;
  } pend_t;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] din;
    logic        exp;
  } vec_t;

  pend_t pq[$];
  vec_t  tbl[$];
  logic  exp_v = 1'b0;
  logic  exp_o = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; results emerge two sampling edges later.
  task automatic step(input logic v, input logic [4:0] s, input logic [31:0] d,
                      input logic e, input string name);
    pend_t p;
    @(negedge clk);
    bus.in_valid = v;
    bus.sel      = s;
    bus.in       = d;
    pq.push_back('{v: v, e: e});
    @(posedge clk);
    #1;
    if (pq.size() >= 2) begin
      p = pq.pop_front();
      exp_v = p.v;
      if (p.v) exp_o = p.e;
    end
    chk({name, "_valid"}, bus.out_valid, exp_v);
    chk({name, "_out"},   bus.out,       exp_o);
  endtask

  task automatic rand_step(input logic v, input string name);
    logic [4:0]  s;
    logic [31:0] d;
    s = 5'($urandom_range(31, 0));
    d = $urandom;
    step(v, s, d, d[s], name);
  endtask

  initial begin
    int b [6] = '{7, 8, 15, 16, 23, 24};
    logic [31:0] one;

    bus.in_valid = 1'b0;
    bus.sel      = '0;
    bus.in       = '0;

    #1;
    chk("reset_out",   bus.out,       1'b0);
    chk("reset_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing comes out.
    step(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, "idle");
    step(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, "idle");

    for (int k = 0; k < 32; k++) begin
      one = 32'h1 << k;
      tbl.push_back('{sel: k[4:0], din: one, exp: 1'b1});
    end
    tbl.push_back('{sel: 5'd0,  din: 32'h0000_0002, exp: 1'b0});
    tbl.push_back('{sel: 5'd31, din: 32'h8000_0000, exp: 1'b1});
    tbl.push_back('{sel: 5'd31, din: 32'h0000_0000, exp: 1'b0});
    for (int i = 0; i < 6; i++) begin
      one = 32'h1 << b[i];
      tbl.push_back('{sel: b[i][4:0], din: ~one, exp: 1'b0});
      tbl.push_back('{sel: b[i][4:0], din: one,  exp: 1'b1});
    end

    foreach (tbl[i]) step(1'b1, tbl[i].sel, tbl[i].din, tbl[i].exp, "table");
    step(1'b0, 5'd0, 32'h0, 1'b0, "flush");
    step(1'b0, 5'd0, 32'h0, 1'b0, "flush");

    // Bubble 1,0,1: the bubble's data would select 0 if it were wrongly loaded.
    step(1'b1, 5'd3,  32'h0000_0008, 1'b1, "bubble");
    step(1'b0, 5'd3,  32'h0000_0000, 1'b0, "bubble");
    step(1'b1, 5'd9,  32'hFFFF_FDFF, 1'b0, "bubble");
    step(1'b0, 5'd9,  32'hFFFF_FFFF, 1'b0, "bubble");
    step(1'b0, 5'd9,  32'hFFFF_FFFF, 1'b0, "bubble");

    for (int i = 0; i < 32; i++) rand_step(1'b1, "stream");
    for (int i = 0; i < 40; i++) rand_step(1'($urandom_range(1, 0)), "mixed");

    // Reset between edges with selections in flight.
    rand_step(1'b1, "pre_rst");
    rand_step(1'b1, "pre_rst");
    rand_step(1'b1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out",   bus.out,       1'b0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    pq.delete();
    exp_v = 1'b0;
    exp_o = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 5'd5, 32'hFFFF_FFFF, 1'b0, "post_rst");
    step(1'b0, 5'd5, 32'hFFFF_FFFF, 1'b0, "post_rst");
    step(1'b1, 5'd5, 32'h0000_0020, 1'b1, "post_rst");
    step(1'b0, 5'd0, 32'h0, 1'b0, "post_rst");
    step(1'b0, 5'd0, 32'h0, 1'b0, "post_rst");
    for (int i = 0; i < 16; i++) rand_step(1'b1, "tail");
    step(1'b0, 5'd0, 32'h0, 1'b0, "tail_flush");
    step(1'b0, 5'd0, 32'h0, 1'b0, "tail_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
